sram_mem_stage: RTL and testbench

- MEM-stage data-memory controller. Sits between EXE_Stage_Reg and MEM_Stage_Reg.
- Turns each 32-bit LDR/STR from EXE into two 16-bit accesses on an external single-port SRAM.
- Holds `ready` low while an access is in flight. The top level drives the pipeline freeze from `~ready`.

---
 rtl/arm_mem_pkg.sv | 23 ++
 rtl/sram_wait_counter.sv | 26 ++
 rtl/sram_mem_stage.sv | 104 ++++++++++
 tb/tb_sram_mem_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared types and constants for the MEM-stage SRAM controller
package arm_mem_pkg;

  localparam int          SRAM_ADDR_W       = 18;
  localparam int          SRAM_DATA_W       = 16;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } mem_state_e;

  // Byte address to 32-bit SRAM word index; the two low offset bits are dropped.
  function automatic logic [SRAM_ADDR_W-2:0] word_addr(input logic [31:0] alu_res,
                                                      input logic [31:0] base);
    logic [31:0] off;
    off = alu_res - base;
    return off[SRAM_ADDR_W:2];
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - counts the cycles of one SRAM half-access
module sram_wait_counter #(
  parameter int SRAM_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign last = (cnt == 4'(SRAM_CYCLES - 1));

endmodule

// File: rtl/sram_mem_stage.sv
// rtl/sram_mem_stage.sv - splits 32-bit loads/stores into two 16-bit SRAM half-accesses
module sram_mem_stage
  import arm_mem_pkg::*;
#(
  parameter int          SRAM_CYCLES = 3,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read_en,
  input  logic                   mem_write_en,
  input  logic [31:0]            alu_res,
  input  logic [31:0]            val_Rm,
  output logic                   ready,
  output logic [31:0]            mem_result,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_wdata,
  input  logic [SRAM_DATA_W-1:0] sram_rdata,
  output logic                   sram_we_n
);

  mem_state_e             state, next;
  logic                   req, wr;
  logic [SRAM_ADDR_W-2:0] waddr;
  logic                   cnt_clear, cnt_en, last;
  logic                   cap_lo, cap_hi;

  // A simultaneous read and write request is served as a read.
  assign req   = mem_read_en | mem_write_en;
  assign wr    = mem_write_en & ~mem_read_en;
  assign waddr = word_addr(alu_res, BASE_ADDR);

  sram_wait_counter #(.SRAM_CYCLES(SRAM_CYCLES)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mem_result <= '0;
    end else begin
      state <= next;
      if (cap_lo) mem_result[15:0]  <= sram_rdata;
      if (cap_hi) mem_result[31:16] <= sram_rdata;
    end
  end

  always_comb begin
    next       = state;
    ready      = 1'b1;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    cap_lo     = 1'b0;
    cap_hi     = 1'b0;
    case (state)
      IDLE: begin
        ready = ~req;
        if (req) begin
          next      = LO;
          cnt_clear = 1'b1;
        end
      end
      LO: begin
        ready      = 1'b0;
        sram_addr  = {waddr, 1'b0};
        sram_wdata = val_Rm[15:0];
        sram_we_n  = ~wr;
        if (last) begin
          cap_lo    = mem_read_en;
          next      = HI;
          cnt_clear = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      HI: begin
        ready      = 1'b0;
        sram_addr  = {waddr, 1'b1};
        sram_wdata = val_Rm[31:16];
        sram_we_n  = ~wr;
        if (last) begin
          cap_hi    = mem_read_en;
          next      = DONE;
          cnt_clear = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        next      = IDLE;
        cnt_clear = 1'b1;
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_mem_stage.sv
// tb/tb_sram_mem_stage.sv - self-checking bench for sram_mem_stage
module tb_sram_mem_stage;

  localparam int          N    = 3;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_en, mem_write_en;
  logic [31:0] alu_res, val_Rm;
  logic        ready;
  logic [31:0] mem_result;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata;
  logic        sram_we_n;

  int checks = 0;
  int errors = 0;

  bit   [15:0] sram_mem [0:262143];
  bit   [15:0] ref_mem  [0:262143];
  logic [31:0] exp_result;

  always #5 clk = ~clk;

  sram_mem_stage #(.SRAM_CYCLES(N), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .alu_res      (alu_res),
    .val_Rm       (val_Rm),
    .ready        (ready),
    .mem_result   (mem_result),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_we_n    (sram_we_n)
  );

  // External single-port SRAM: combinational read, write on the clock edge.
  assign sram_rdata = sram_mem[sram_addr];
  always @(posedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr] <= sram_wdata;
  end

  // A request must never drop while an access is in flight.
  always @(posedge clk) begin
    if (rst && !ready && !(mem_read_en | mem_write_en)) begin
      errors++;
      $display("FAIL req_dropped: request low while ready=0 at %0t", $time);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    alu_res      = 32'h0;
    val_Rm       = 32'h0;
  endtask

  // Issues one request (called just after a rising edge) and follows it to DONE.
  task automatic do_op(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, output int low, output logic [31:0] res);
    logic [31:0] off;
    int          w;
    bit          done;
    logic        wr_eff;
    wr_eff = wr & ~rd;
    off    = addr - BASE;
    w      = int'((off >> 2) % 32'd131072);
    mem_read_en  = rd;
    mem_write_en = wr;
    alu_res      = addr;
    val_Rm       = data;
    low  = 0;
    done = 0;
    res  = 32'h0;
    while (!done) begin
      @(negedge clk);
      if (ready) begin
        done = 1;
      end else begin
        if (low == 0) begin
          check("req_cycle_we_n", 32'(sram_we_n), 32'd1);
          check("req_cycle_addr", 32'(sram_addr), 32'd0);
        end else if (low <= N) begin
          check("lo_addr",  32'(sram_addr), 32'(2 * w));
          check("lo_wdata", 32'(sram_wdata), 32'(data[15:0]));
          check("lo_we_n",  32'(sram_we_n), 32'(!wr_eff));
        end else if (low <= 2 * N) begin
          check("hi_addr",  32'(sram_addr), 32'(2 * w + 1));
          check("hi_wdata", 32'(sram_wdata), 32'(data[31:16]));
          check("hi_we_n",  32'(sram_we_n), 32'(!wr_eff));
        end
        low++;
        if (low > 2 * N + 5) begin
          errors++;
          $display("FAIL timeout: ready never returned high after %0d cycles", low);
          done = 1;
        end
      end
    end
    if (rd) begin
      exp_result = {ref_mem[2 * w + 1], ref_mem[2 * w]};
    end else if (wr) begin
      ref_mem[2 * w]     = data[15:0];
      ref_mem[2 * w + 1] = data[31:16];
    end
    res = mem_result;
    check("latency",    32'(low), 32'(2 * N + 1));
    check("done_we_n",  32'(sram_we_n), 32'd1);
    check("mem_result", mem_result, exp_result);
    @(posedge clk);
    #1;
    set_idle();
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[6];
  int          low;
  logic [31:0] res;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 32'd1032, 32'hABCD1234, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 32'd1032, 32'h55AA55AA, 32'hABCD1234};
    vecs[4] = '{1'b0, 1'b1, 32'd1028, 32'h0000FFFF, 32'hABCD1234};
    vecs[5] = '{1'b1, 1'b0, 32'd1028, 32'h0000FFFF, 32'h0000FFFF};

    exp_result = 32'h0;
    set_idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready",      32'(ready), 32'd1);
    check("reset_we_n",       32'(sram_we_n), 32'd1);
    check("reset_mem_result", mem_result, 32'h0);
    check("reset_addr",       32'(sram_addr), 32'd0);
    check("reset_wdata",      32'(sram_wdata), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, issued back-to-back.
    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, low, res);
      check("tbl_result", res, vecs[i].exp_res);
      check("tbl_latency", 32'(low), 32'd7);
    end

    // Reset during the second HI cycle of a load.
    mem_read_en = 1'b1;
    alu_res     = 32'd1024;
    repeat (N + 3) @(negedge clk);
    check("rst_mid_busy", 32'(ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_mem_result", mem_result, 32'h0);
    check("rst_mid_we_n",       32'(sram_we_n), 32'd1);
    check("rst_mid_addr",       32'(sram_addr), 32'd0);
    rst = 1'b1;
    set_idle();
    exp_result = 32'h0;
    @(negedge clk);
    check("rst_mid_idle_ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    do_op(1'b1, 1'b0, 32'd1024, 32'h0, low, res);
    check("rst_mid_reload", res, 32'hDEADBEEF);

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 40; i++) begin
      logic        rd, wr;
      logic [31:0] addr;
      int          gap;
      rd   = 1'($urandom_range(0, 1));
      wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      addr = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
      do_op(rd, wr, addr, $urandom, low, res);
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
